cache_main_memory: RTL

Memory-side responder for the cache's memory port. It serves 32-bit block reads on a cache miss and single-byte write-through writes. Storage is a 256-byte array with programmable response latency. The block sits directly opposite the cache's `M*` signals and replaces the hand-driven memory stimulus in system-level simulation and FPGA bring-up.

---
 rtl/cache_mem_pkg.sv | 26 ++
 rtl/mem_byte_array.sv | 34 +++
 rtl/cache_main_memory.sv | 107 ++++++++++
 3 files changed

// File: rtl/cache_mem_pkg.sv
// Types and sizes shared by the cache and its memory-side responder.
package cache_mem_pkg;

    localparam int ADDR_W          = 8;
    localparam int DATA_W          = 8;
    localparam int BLOCK_W         = 32;
    localparam int WORDS_PER_BLOCK = 4;
    localparam int OFF_W           = $clog2(WORDS_PER_BLOCK);
    localparam int MEM_DEPTH       = 1 << ADDR_W;
    localparam int CNT_W           = 4;

    typedef enum logic [2:0] {
        IDLE,
        READ_WAIT,
        READ_RESP,
        WRITE_WAIT,
        WRITE_RESP,
        RELEASE
    } mem_state_t;

    // Counter preload so that the response lands exactly LAT edges after acceptance.
    function automatic logic [CNT_W-1:0] lat_load(input int lat);
        return CNT_W'(lat - 1);
    endfunction

endpackage

// File: rtl/mem_byte_array.sv
// 256x8 byte store: reset image mem[i]=i, one synchronous byte write port and
// a combinational 4-byte block read port.
module mem_byte_array
    import cache_mem_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en_i,
    input  logic [ADDR_W-1:0]       wr_addr_i,
    input  logic [DATA_W-1:0]       wr_data_i,
    input  logic [ADDR_W-OFF_W-1:0] rd_block_i,
    output logic [BLOCK_W-1:0]      rd_block_data_o
);

    logic [DATA_W-1:0] mem_q [MEM_DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= DATA_W'(i);
            end
        end else if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Lane k carries the byte at offset k within the block.
    generate
        for (genvar gi = 0; gi < WORDS_PER_BLOCK; gi++) begin : g_lane
            assign rd_block_data_o[gi*DATA_W +: DATA_W] = mem_q[{rd_block_i, OFF_W'(gi)}];
        end
    endgenerate

endmodule

// File: rtl/cache_main_memory.sv
// Memory-side responder for the cache: block reads and byte write-through
// writes with programmable latency, one response per accepted request.
module cache_main_memory
    import cache_mem_pkg::*;
#(
    parameter int READ_LATENCY  = 4,
    parameter int WRITE_LATENCY = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               MRead_request,
    input  logic               MWrite_request,
    input  logic [ADDR_W-1:0]  MAddress,
    input  logic [DATA_W-1:0]  MWrite_data,
    output logic               MRead_ready,
    output logic [BLOCK_W-1:0] MRead_data,
    output logic               MWrite_done
);

    mem_state_t         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [BLOCK_W-1:0] rdata_q, rdata_d;
    logic               mem_we;
    logic [BLOCK_W-1:0] block_data;

    mem_byte_array u_array (
        .clk             (clk),
        .rst             (rst),
        .wr_en_i         (mem_we),
        .wr_addr_i       (addr_q),
        .wr_data_i       (wdata_q),
        .rd_block_i      (addr_q[ADDR_W-1:OFF_W]),
        .rd_block_data_o (block_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                // Write wins so a write-through byte lands before any aliasing read.
                if (MWrite_request) begin
                    state_d = WRITE_WAIT;
                    addr_d  = MAddress;
                    wdata_d = MWrite_data;
                    cnt_d   = lat_load(WRITE_LATENCY);
                end else if (MRead_request) begin
                    state_d = READ_WAIT;
                    addr_d  = MAddress;
                    cnt_d   = lat_load(READ_LATENCY);
                end
            end
            READ_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = READ_RESP;
                    rdata_d = block_data;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            READ_RESP: state_d = RELEASE;
            WRITE_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = WRITE_RESP;
                    mem_we  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            WRITE_RESP: state_d = RELEASE;
            RELEASE: begin
                // Wait for the requester to drop so a held request is not serviced twice.
                if (!MRead_request && !MWrite_request) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign MRead_ready = (state_q == READ_RESP);
    assign MWrite_done = (state_q == WRITE_RESP);
    assign MRead_data  = rdata_q;

endmodule
